// File: rtl/miss_tracker_display.sv
// rtl/miss_tracker_display.sv - miss counter with game-over detection and blinking seven-segment digit
module miss_tracker_display #(
  parameter int MAX_MISSES    = 3,
  parameter int DISPLAY_LIVES = 0,
  parameter int BLINK_HALF    = 12_500_000,
  parameter int FLASH_TOGGLES = 6,
  parameter int CW            = $clog2(MAX_MISSES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          game_start,
  input  logic          miss_in,
  output logic [CW-1:0] miss_count,
  output logic [CW-1:0] lives_left,
  output logic          miss_flag,
  output logic          game_over,
  output logic [6:0]    hex_out
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TW = $clog2(FLASH_TOGGLES + 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] TOGGLE_LAST = TW'(FLASH_TOGGLES - 1);
  localparam logic [CW-1:0] MAX_C       = CW'(MAX_MISSES);

  typedef enum logic [1:0] {IDLE, PLAY, FLASH, OVER} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  localparam logic [6:0] HEX_RST = seg7((DISPLAY_LIVES != 0) ? 4'(MAX_MISSES) : 4'd0);

  state_t        state_q;
  logic          miss_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          flag_q;
  logic          over_q;
  logic          blank_q;
  logic [BW-1:0] blink_q;
  logic [TW-1:0] toggle_q;
  logic [6:0]    hex_q;
  logic [CW-1:0] disp;
  logic          rise;

  assign rise       = miss_in & ~miss_q;
  assign count_d    = count_q + CW'(1);
  assign lives_left = MAX_C - count_q;
  assign disp       = (DISPLAY_LIVES != 0) ? lives_left : count_q;

  assign miss_count = count_q;
  assign miss_flag  = flag_q;
  assign game_over  = over_q;
  assign hex_out    = hex_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      miss_q   <= 1'b0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      over_q   <= 1'b0;
      blank_q  <= 1'b0;
      blink_q  <= '0;
      toggle_q <= '0;
      hex_q    <= HEX_RST;
    end else begin
      miss_q <= miss_in;
      flag_q <= 1'b0;
      hex_q  <= blank_q ? 7'b1111111 : seg7(4'(disp));
      // game_start wins over a coincident rise, which is simply dropped
      if (game_start) begin
        state_q  <= PLAY;
        count_q  <= '0;
        over_q   <= 1'b0;
        blank_q  <= 1'b0;
        blink_q  <= '0;
        toggle_q <= '0;
      end else if (rise && (state_q == PLAY || state_q == FLASH)) begin
        count_q  <= count_d;
        flag_q   <= 1'b1;
        blink_q  <= '0;
        toggle_q <= '0;
        if (count_d == MAX_C) begin
          state_q <= OVER;
          over_q  <= 1'b1;
          blank_q <= 1'b0;
        end else begin
          state_q <= FLASH;
          blank_q <= 1'b1;
        end
      end else begin
        case (state_q)
          FLASH: begin
            if (blink_q == BLINK_LAST) begin
              blink_q <= '0;
              if (toggle_q == TOGGLE_LAST) begin
                state_q  <= PLAY;
                blank_q  <= 1'b0;
                toggle_q <= '0;
              end else begin
                toggle_q <= toggle_q + TW'(1);
                blank_q  <= ~blank_q;
              end
            end else begin
              blink_q <= blink_q + BW'(1);
            end
          end
          OVER: begin
            if (blink_q == BLINK_LAST) begin
              blink_q <= '0;
              blank_q <= ~blank_q;
            end else begin
              blink_q <= blink_q + BW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_miss_tracker_display.sv
// tb/tb_miss_tracker_display.sv - randomized and directed check of two miss_tracker_display configurations
module tb_miss_tracker_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gs  = 1'b0;
  logic miss = 1'b0;

  logic [1:0] a_cnt, a_lives;
  logic       a_flag, a_over;
  logic [6:0] a_hex;
  logic [2:0] b_cnt, b_lives;
  logic       b_flag, b_over;
  logic [6:0] b_hex;

  always #5 clk = ~clk;

  miss_tracker_display #(.MAX_MISSES(3), .DISPLAY_LIVES(0), .BLINK_HALF(4), .FLASH_TOGGLES(4)) dut_a (
    .clk(clk), .reset(rst), .game_start(gs), .miss_in(miss),
    .miss_count(a_cnt), .lives_left(a_lives), .miss_flag(a_flag), .game_over(a_over), .hex_out(a_hex));

  miss_tracker_display #(.MAX_MISSES(5), .DISPLAY_LIVES(1), .BLINK_HALF(3), .FLASH_TOGGLES(2)) dut_b (
    .clk(clk), .reset(rst), .game_start(gs), .miss_in(miss),
    .miss_count(b_cnt), .lives_left(b_lives), .miss_flag(b_flag), .game_over(b_over), .hex_out(b_hex));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: seg = 7'b1000000;  1: seg = 7'b1111001;  2: seg = 7'b0100100;
      3: seg = 7'b0110000;  4: seg = 7'b0011001;  5: seg = 7'b0010010;
      6: seg = 7'b0000010;  7: seg = 7'b1111000;  8: seg = 7'b0000000;
      9: seg = 7'b0010000;  default: seg = 7'b1111111;
    endcase
  endfunction

  // Model: per instance, mode plus elapsed cycles t since the current flash/over phase began
  localparam int M_IDLE = 0, M_PLAY = 1, M_FLASH = 2, M_OVER = 3;
  int p_max[2] = '{3, 5};
  int p_dl[2]  = '{0, 1};
  int p_bh[2]  = '{4, 3};
  int p_ft[2]  = '{4, 2};
  int m_mode[2] = '{0, 0};
  int m_cnt[2]  = '{0, 0};
  int m_t[2]    = '{0, 0};
  int m_flag[2] = '{0, 0};
  int m_prev[2] = '{0, 0};
  logic [6:0] m_hex[2];

  function automatic bit mblank(input int i);
    if (m_mode[i] == M_FLASH) return ((m_t[i] / p_bh[i]) % 2) == 0;
    if (m_mode[i] == M_OVER)  return ((m_t[i] / p_bh[i]) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic step(input int i);
    int disp;
    bit bl;
    bit rise;
    bl   = mblank(i);
    disp = p_dl[i] ? p_max[i] - m_cnt[i] : m_cnt[i];
    if (rst) begin
      m_hex[i]  = seg(p_dl[i] ? p_max[i] : 0);
      m_mode[i] = M_IDLE; m_cnt[i] = 0; m_flag[i] = 0; m_t[i] = 0; m_prev[i] = 0;
    end else begin
      m_hex[i]  = bl ? 7'b1111111 : seg(disp);
      rise      = miss && (m_prev[i] == 0);
      m_prev[i] = miss;
      m_flag[i] = 0;
      if (gs) begin
        m_mode[i] = M_PLAY; m_cnt[i] = 0; m_t[i] = 0;
      end else if (rise && (m_mode[i] == M_PLAY || m_mode[i] == M_FLASH)) begin
        m_cnt[i]++;
        m_flag[i] = 1;
        m_t[i]    = 0;
        m_mode[i] = (m_cnt[i] == p_max[i]) ? M_OVER : M_FLASH;
      end else if (m_mode[i] == M_FLASH) begin
        m_t[i]++;
        if (m_t[i] == p_bh[i] * p_ft[i]) m_mode[i] = M_PLAY;
      end else if (m_mode[i] == M_OVER) begin
        m_t[i]++;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) step(i);
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("A.miss_count", a_cnt, m_cnt[0]);
      check("A.lives_left", a_lives, p_max[0] - m_cnt[0]);
      check("A.miss_flag", a_flag, m_flag[0]);
      check("A.game_over", a_over, m_mode[0] == M_OVER);
      check("A.hex_out", a_hex, m_hex[0]);
      check("B.miss_count", b_cnt, m_cnt[1]);
      check("B.lives_left", b_lives, p_max[1] - m_cnt[1]);
      check("B.miss_flag", b_flag, m_flag[1]);
      check("B.game_over", b_over, m_mode[1] == M_OVER);
      check("B.hex_out", b_hex, m_hex[1]);
    end
  end

  task automatic tick(input logic r, input logic g, input logic m);
    rst = r; gs = g; miss = m;
    @(negedge clk);
  endtask

  task automatic pulse(input int gap);
    tick(0, 0, 1);
    repeat (gap) tick(0, 0, 0);
  endtask

  int flags;
  logic rm;

  initial begin
    tick(1, 0, 0);
    chk_en = 1'b1;
    tick(1, 0, 0);
    check("pin.reset_hexA", a_hex, 7'b1000000);
    check("pin.reset_hexB", b_hex, 7'b0010010);
    check("pin.reset_cntA", a_cnt, 0);

    // held level counts once; flash then steady digit
    tick(0, 1, 0);
    flags = 0;
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 1);
      flags += a_flag;
      if (k == 0) check("pin.held_cnt", a_cnt, 1);
      if (k == 1) check("pin.held_blank", a_hex, 7'b1111111);
    end
    repeat (10) begin tick(0, 0, 0); flags += a_flag; end
    check("pin.held_flags", flags, 1);
    check("pin.held_digit", a_hex, 7'b1111001);

    // three misses reach game over, fourth ignored
    tick(0, 1, 0);
    for (int k = 0; k < 3; k++) pulse(3);
    check("pin.over", a_over, 1);
    check("pin.over_cnt", a_cnt, 3);
    tick(0, 0, 1);
    check("pin.over_noflag", a_flag, 0);
    check("pin.over_hold", a_cnt, 3);
    repeat (12) tick(0, 0, 0);

    // second miss restarts the flash
    tick(0, 1, 0);
    pulse(4);
    tick(0, 0, 1);
    check("pin.restart_cnt", a_cnt, 2);
    repeat (10) tick(0, 0, 0);
    check("pin.restart_blank", a_hex, 7'b1111111);
    repeat (10) tick(0, 0, 0);
    check("pin.restart_digit", a_hex, 7'b0100100);

    // game_start beats a coincident rise
    tick(0, 1, 1);
    check("pin.gs_cnt", a_cnt, 0);
    check("pin.gs_flag", a_flag, 0);
    tick(0, 0, 0);
    check("pin.gs_hex", a_hex, 7'b1000000);

    // lives display
    tick(0, 1, 0);
    pulse(3);
    pulse(12);
    check("pin.lives", b_lives, 3);
    check("pin.lives_hex", b_hex, 7'b0110000);

    // reset mid-flash and mid-over
    tick(0, 1, 0);
    pulse(2);
    tick(1, 0, 1);
    check("pin.rst_flash_cnt", a_cnt, 0);
    check("pin.rst_flash_flag", a_flag, 0);
    tick(0, 0, 0);
    check("pin.rst_flash_hex", a_hex, 7'b1000000);
    for (int k = 0; k < 3; k++) pulse(1);
    check("pin.rst_ignored", a_cnt, 0);
    tick(0, 1, 0);
    for (int k = 0; k < 3; k++) pulse(1);
    check("pin.over2", a_over, 1);
    tick(1, 0, 0);
    check("pin.rst_over", a_over, 0);
    check("pin.rst_over_cnt", a_cnt, 0);

    rm = 1'b0;
    repeat (4000) begin
      if ($urandom_range(0, 2) == 0) rm = ~rm;
      tick($urandom_range(0, 399) == 0, $urandom_range(0, 59) == 0, rm);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
